// File: rtl/pwm_ramp_scheduler.sv
// Two-channel ramp scheduler: on each tick, steps each channel's current value toward its target.
// Loads go to a shared dual-PWM value bus, one channel at a time, with round-robin arbitration and a minimum gap between loads.
module pwm_ramp_scheduler #(
    parameter int C_PWM_WIDTH = 24,
    parameter int C_TICK_DIV  = 1000,
    parameter int C_LOAD_GAP  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [C_PWM_WIDTH-1:0] cfg_value_i,
    input  logic [1:0]             cfg_wr_target_i,
    input  logic [1:0]             cfg_wr_step_i,
    output logic [C_PWM_WIDTH-1:0] pwm_value_o,
    output logic [1:0]             pwm_value_load_o,
    output logic                   pwm_rst_o,
    output logic [C_PWM_WIDTH-1:0] cur0_o,
    output logic [C_PWM_WIDTH-1:0] cur1_o,
    output logic [1:0]             ramping_o,
    output logic                   busy_o,
    output logic [1:0]             dbg_state_o
);

    localparam int TW = $clog2(C_TICK_DIV);
    localparam int GW = $clog2(C_LOAD_GAP);
    localparam logic [TW-1:0] LP_TICK_LAST = TW'(C_TICK_DIV - 1);
    localparam logic [GW-1:0] LP_GAP_LAST  = GW'(C_LOAD_GAP - 2);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_LOAD, ST_GAP} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [TW-1:0]          r_tick_cnt;
    logic [GW-1:0]          r_gap_cnt;
    logic [C_PWM_WIDTH-1:0] r_target [2];
    logic [C_PWM_WIDTH-1:0] r_step   [2];
    logic [C_PWM_WIDTH-1:0] r_cur    [2];
    logic [C_PWM_WIDTH-1:0] r_value;
    logic [1:0]             r_pending;
    logic                   r_last;
    logic                   r_sel;

    logic                   w_tick;
    logic                   w_gap_done;
    logic                   w_pick;
    logic                   w_enter_load;
    logic [1:0]             w_neq;
    logic [1:0]             w_load_clr;
    logic [1:0]             w_pending_next;
    logic [C_PWM_WIDTH-1:0] w_cur;
    logic [C_PWM_WIDTH-1:0] w_tgt;
    logic [C_PWM_WIDTH-1:0] w_stp;
    logic [C_PWM_WIDTH-1:0] w_diff;
    logic                   w_up;
    logic [C_PWM_WIDTH-1:0] w_next;

    assign w_tick     = (r_tick_cnt == LP_TICK_LAST);
    assign w_gap_done = (r_gap_cnt == LP_GAP_LAST);
    assign w_neq      = {r_cur[1] != r_target[1], r_cur[0] != r_target[0]};
    // Both pending: serve the channel not served last; otherwise serve whichever is pending.
    assign w_pick     = (r_pending == 2'b11) ? ~r_last : r_pending[1];
    assign w_load_clr = (r_state == ST_LOAD) ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
    assign w_pending_next = (r_pending & ~w_load_clr) | ({2{w_tick}} & ~r_pending & w_neq);

    // Magnitude compare against the step keeps the update within [cur, target] at full width.
    assign w_cur  = r_cur[r_sel];
    assign w_tgt  = r_target[r_sel];
    assign w_stp  = r_step[r_sel];
    assign w_up   = (w_tgt > w_cur);
    assign w_diff = w_up ? (w_tgt - w_cur) : (w_cur - w_tgt);
    assign w_next = ((w_stp == '0) || (w_diff <= w_stp)) ? w_tgt
                  : (w_up ? (w_cur + w_stp) : (w_cur - w_stp));

    // The last GAP cycle arbitrates like IDLE so back-to-back loads land exactly C_LOAD_GAP apart.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: w_state_next = ST_GAP;
            ST_IDLE: if (|r_pending) w_state_next = ST_LOAD;
            ST_LOAD: w_state_next = ST_GAP;
            ST_GAP:  if (w_gap_done) w_state_next = (|r_pending) ? ST_LOAD : ST_IDLE;
            default: w_state_next = ST_INIT;
        endcase
    end

    assign w_enter_load = (w_state_next == ST_LOAD) && (r_state != ST_LOAD);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_INIT;
            r_gap_cnt <= '0;
            r_sel     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_gap_cnt <= ((r_state != ST_GAP) || w_gap_done) ? '0 : r_gap_cnt + GW'(1);
            if (w_enter_load) r_sel <= w_pick;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_tick_cnt <= '0;
            r_pending  <= 2'b00;
            r_last     <= 1'b1;
            r_value    <= '0;
            for (int n = 0; n < 2; n++) begin
                r_target[n] <= '0;
                r_step[n]   <= '0;
                r_cur[n]    <= '0;
            end
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_pending  <= w_pending_next;
            for (int n = 0; n < 2; n++) begin
                if (cfg_wr_target_i[n]) r_target[n] <= cfg_value_i;
                if (cfg_wr_step_i[n])   r_step[n]   <= cfg_value_i;
            end
            if (r_state == ST_LOAD) begin
                r_cur[r_sel] <= w_next;
                r_value      <= w_next;
                r_last       <= r_sel;
            end
        end
    end

    // Strobes and the value bus are gated by reset so an abort takes effect in the same cycle.
    assign pwm_value_load_o = rst_n_i ? w_load_clr : 2'b00;
    assign pwm_value_o      = !rst_n_i ? '0 : ((r_state == ST_LOAD) ? w_next : r_value);
    assign pwm_rst_o        = rst_n_i && (r_state == ST_INIT);
    assign busy_o           = !rst_n_i || (r_state != ST_IDLE);
    assign ramping_o        = rst_n_i ? w_neq : 2'b00;
    assign cur0_o           = r_cur[0];
    assign cur1_o           = r_cur[1];
    assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Bench for pwm_ramp_scheduler: directed ramp scenarios plus randomized cfg writes and resets.
// Every cycle is compared against a cycle-count based behavioural model.
module tb_pwm_ramp_scheduler;

    localparam int W   = 24;
    localparam int DIV = 40;
    localparam int GAP = 16;

    logic         clk = 1'b0;
    logic         rst_n_i;
    logic [W-1:0] cfg_value_i;
    logic [1:0]   cfg_wr_target_i;
    logic [1:0]   cfg_wr_step_i;
    logic [W-1:0] pwm_value_o;
    logic [1:0]   pwm_value_load_o;
    logic         pwm_rst_o;
    logic [W-1:0] cur0_o;
    logic [W-1:0] cur1_o;
    logic [1:0]   ramping_o;
    logic         busy_o;
    logic [1:0]   dbg_state_o;

    pwm_ramp_scheduler #(
        .C_PWM_WIDTH (W),
        .C_TICK_DIV  (DIV),
        .C_LOAD_GAP  (GAP)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n_i),
        .cfg_value_i      (cfg_value_i),
        .cfg_wr_target_i  (cfg_wr_target_i),
        .cfg_wr_step_i    (cfg_wr_step_i),
        .pwm_value_o      (pwm_value_o),
        .pwm_value_load_o (pwm_value_load_o),
        .pwm_rst_o        (pwm_rst_o),
        .cur0_o           (cur0_o),
        .cur1_o           (cur1_o),
        .ramping_o        (ramping_o),
        .busy_o           (busy_o),
        .dbg_state_o      (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int           cyc;
        int           ch;
        logic [W-1:0] val;
    } load_t;

    load_t        log_q[$];
    logic [W-1:0] exp_q[$];
    int           n_checks   = 0;
    int           n_fail     = 0;
    int           rst_pulses = 0;

    // Model: cycle numbers count from 1 = first cycle with reset released.
    int           m_cyc      = 0;
    logic [W-1:0] m_cur  [2] = '{default: '0};
    logic [W-1:0] m_tgt  [2] = '{default: '0};
    logic [W-1:0] m_step [2] = '{default: '0};
    logic [W-1:0] m_hold     = '0;
    logic [1:0]   m_pend     = 2'b00;
    int           m_last     = 1;
    int           m_sel      = 0;
    int           m_load_cyc = -1;
    int           m_gap_end  = GAP;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ramp_next(input logic [W-1:0] cur, input logic [W-1:0] tgt,
                                                input logic [W-1:0] stp);
        longint c = longint'(cur);
        longint t = longint'(tgt);
        longint s = longint'(stp);
        longint d = t - c;
        longint a = (d < 0) ? -d : d;
        if (s == 0 || a <= s) return tgt;
        return (d > 0) ? W'(c + s) : W'(c - s);
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic         load_now;
        logic         tick;
        logic [W-1:0] nxt;
        logic [1:0]   exp_load;
        nxt = '0;
        if (pwm_value_load_o != 2'b00)
            log_q.push_back('{m_cyc, (pwm_value_load_o[1] ? 1 : 0), pwm_value_o});
        if (!rst_n_i) begin
            chk("load_in_reset",    {30'd0, pwm_value_load_o}, 32'd0);
            chk("value_in_reset",   {8'd0, pwm_value_o}, 32'd0);
            chk("pwmrst_in_reset",  {31'd0, pwm_rst_o}, 32'd0);
            chk("ramping_in_reset", {30'd0, ramping_o}, 32'd0);
            chk("busy_in_reset",    {31'd0, busy_o}, 32'd1);
            chk("cur0_in_reset",    {8'd0, cur0_o}, {8'd0, m_cur[0]});
            chk("cur1_in_reset",    {8'd0, cur1_o}, {8'd0, m_cur[1]});
            m_cyc = 0; m_hold = '0; m_pend = 2'b00; m_last = 1; m_sel = 0;
            m_load_cyc = -1; m_gap_end = GAP;
            for (int n = 0; n < 2; n++) begin
                m_cur[n] = '0; m_tgt[n] = '0; m_step[n] = '0;
            end
        end else begin
            m_cyc++;
            load_now = (m_cyc == m_load_cyc);
            tick     = ((m_cyc % DIV) == 0);
            if (load_now) begin
                nxt    = ramp_next(m_cur[m_sel], m_tgt[m_sel], m_step[m_sel]);
                m_hold = nxt;
            end
            exp_load = load_now ? ((m_sel == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk("load_strobe", {30'd0, pwm_value_load_o}, {30'd0, exp_load});
            chk("pwm_value",   {8'd0, pwm_value_o}, {8'd0, m_hold});
            chk("pwm_rst",     {31'd0, pwm_rst_o}, {31'd0, (m_cyc == 1)});
            chk("busy",        {31'd0, busy_o}, {31'd0, !(m_cyc > m_gap_end && !load_now)});
            chk("ramping",     {30'd0, ramping_o},
                {30'd0, (m_cur[1] != m_tgt[1]), (m_cur[0] != m_tgt[0])});
            chk("cur0",        {8'd0, cur0_o}, {8'd0, m_cur[0]});
            chk("cur1",        {8'd0, cur1_o}, {8'd0, m_cur[1]});
            if (pwm_rst_o) rst_pulses++;
            // The FSM is free to arbitrate from the last gap cycle onward.
            if (!load_now && m_cyc >= m_gap_end && m_pend != 2'b00) begin
                m_load_cyc = m_cyc + 1;
                m_sel      = (m_pend == 2'b11) ? (1 - m_last) : (m_pend[1] ? 1 : 0);
            end
            for (int n = 0; n < 2; n++) begin
                if (load_now && m_sel == n) m_pend[n] = 1'b0;
                else if (tick && !m_pend[n] && m_cur[n] != m_tgt[n]) m_pend[n] = 1'b1;
            end
            if (load_now) begin
                m_cur[m_sel] = nxt;
                m_last       = m_sel;
                m_gap_end    = m_cyc + GAP - 1;
            end
            for (int n = 0; n < 2; n++) begin
                if (cfg_wr_target_i[n]) m_tgt[n]  = cfg_value_i;
                if (cfg_wr_step_i[n])   m_step[n] = cfg_value_i;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [1:0] wt, input logic [1:0] ws, input logic [W-1:0] v);
        cfg_value_i     = v;
        cfg_wr_target_i = wt;
        cfg_wr_step_i   = ws;
        cyc_step();
        cfg_wr_target_i = 2'b00;
        cfg_wr_step_i   = 2'b00;
    endtask

    task automatic wait_settled(input int budget, input string name);
        int k = 0;
        while ((m_pend != 2'b00 || ramping_o != 2'b00 || busy_o) && k < budget) begin
            cyc_step();
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: still busy/ramping after %0d cycles", name, budget);
        end
    endtask

    task automatic check_log(input string name, input int ch);
        chk({name, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk({name, "_ch"},  log_q[i].ch, ch);
            chk({name, "_val"}, {8'd0, log_q[i].val}, {8'd0, exp_q[i]});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        int p0;
        int k;
        rst_n_i         = 1'b0;
        cfg_value_i     = '0;
        cfg_wr_target_i = 2'b00;
        cfg_wr_step_i   = 2'b00;
        repeat (3) cyc_step();
        rst_n_i = 1'b1;
        repeat (GAP + 4) cyc_step();
        chk("rst_pulse_count", rst_pulses, 1);
        chk("no_loads_after_reset", log_q.size(), 0);
        chk("busy_low_when_idle", {31'd0, busy_o}, 32'd0);

        // Ramp up in four equal steps.
        log_q.delete();
        write_cfg(2'b00, 2'b01, 24'h100000);
        write_cfg(2'b01, 2'b00, 24'h400000);
        wait_settled(600, "ramp_up");
        exp_q = '{24'h100000, 24'h200000, 24'h300000, 24'h400000};
        check_log("ramp_up", 0);
        chk("ramp_up_ramping0", {31'd0, ramping_o[0]}, 32'd0);

        // Ramp down with a step that would underflow past the target.
        log_q.delete();
        write_cfg(2'b00, 2'b01, 24'h300000);
        write_cfg(2'b01, 2'b00, 24'h050000);
        wait_settled(600, "ramp_down");
        exp_q = '{24'h100000, 24'h050000};
        check_log("ramp_down", 0);

        // Zero step jumps straight to the target.
        log_q.delete();
        write_cfg(2'b00, 2'b10, 24'h000000);
        write_cfg(2'b10, 2'b00, 24'hFFFFFF);
        wait_settled(600, "jump");
        exp_q = '{24'hFFFFFF};
        check_log("jump", 1);

        // Both channels retargeted together: alternating service, GAP cycles apart.
        log_q.delete();
        write_cfg(2'b00, 2'b01, 24'h010000);
        write_cfg(2'b00, 2'b10, 24'h800000);
        write_cfg(2'b11, 2'b00, 24'h070000);
        wait_settled(600, "both");
        chk("both_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("both_ch_0", log_q[0].ch, 0);
            chk("both_ch_1", log_q[1].ch, 1);
            chk("both_ch_2", log_q[2].ch, 0);
            chk("both_ch_3", log_q[3].ch, 1);
            chk("both_val_0", {8'd0, log_q[0].val}, 32'h060000);
            chk("both_val_1", {8'd0, log_q[1].val}, 32'h7FFFFF);
            chk("both_val_2", {8'd0, log_q[2].val}, 32'h070000);
            chk("both_val_3", {8'd0, log_q[3].val}, 32'h070000);
            chk("both_gap_a", log_q[1].cyc - log_q[0].cyc, GAP);
            chk("both_gap_b", log_q[3].cyc - log_q[2].cyc, GAP);
            chk("both_tick_period", log_q[2].cyc - log_q[0].cyc, DIV);
        end

        // Reset in the middle of a GAP.
        write_cfg(2'b00, 2'b01, 24'h010000);
        write_cfg(2'b01, 2'b00, 24'h000000);
        k = 0;
        while (pwm_value_load_o == 2'b00 && k < 200) begin
            cyc_step();
            k++;
        end
        chk("gap_reset_saw_load", {31'd0, (k < 200)}, 32'd1);
        repeat (3) cyc_step();
        n0 = log_q.size();
        p0 = rst_pulses;
        rst_n_i = 1'b0;
        repeat (4) cyc_step();
        chk("gap_reset_no_strobes", log_q.size(), n0);
        rst_n_i = 1'b1;
        repeat (GAP + 2) cyc_step();
        chk("gap_reset_reinit_pulse", rst_pulses, p0 + 1);
        chk("gap_reset_cur0", {8'd0, cur0_o}, 32'd0);
        chk("gap_reset_no_loads", log_q.size(), n0);

        // Randomized writes with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                rst_n_i = 1'b0;
                repeat ($urandom_range(1, 3)) cyc_step();
                rst_n_i = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       cfg_value_i = '0;
                    1:       cfg_value_i = W'($urandom_range(1, 32'h40000));
                    2:       cfg_value_i = W'($urandom_range(0, 32'hFFFFFF));
                    default: cfg_value_i = W'($urandom_range(32'hFF0000, 32'hFFFFFF));
                endcase
                cfg_wr_target_i = 2'($urandom_range(0, 3));
                cfg_wr_step_i   = 2'($urandom_range(0, 3));
                cyc_step();
                cfg_wr_target_i = 2'b00;
                cfg_wr_step_i   = 2'b00;
            end else begin
                cyc_step();
            end
        end
        repeat (2) cyc_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
